// File: rtl/regwb_arb.sv
// Round-robin write-back arbiter: three requesters share one registered write port to the register memory.
// Optional stall statistics (conflict_cnt) are built only when REGWB_ARB_STATS_EN is defined.
module regwb_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [2:0]       req,
    input  logic [4:0]       wrreg0,
    input  logic [4:0]       wrreg1,
    input  logic [4:0]       wrreg2,
    input  logic [31:0]      wrdata0,
    input  logic [31:0]      wrdata1,
    input  logic [31:0]      wrdata2,
    output logic [2:0]       gnt,
    output logic             regwrite,
    output logic [4:0]       wrreg,
    output logic [31:0]      wrdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Handshake: requester i transfers on a rising edge where req[i] and gnt[i] are both high;
    // a requester keeps req, wrreg and wrdata stable until that edge.

    logic [1:0]  last;
    logic [1:0]  last_nxt;
    logic [1:0]  last_eff;
    logic [1:0]  start;
    logic [2:0]  rot;
    logic [2:0]  pick;
    logic        xfer;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    // Pointer state register: index of the most recently granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 2'd2;
        end else begin
            last <= last_nxt;
        end
    end

    // Next-state: load the granted index, otherwise hold.
    always_comb begin
        last_nxt = last;
        if (gnt[0]) begin
            last_nxt = 2'd0;
        end else if (gnt[1]) begin
            last_nxt = 2'd1;
        end else if (gnt[2]) begin
            last_nxt = 2'd2;
        end
    end

    // Output: rotate req so the search start sits at bit 0, priority-pick, rotate back.
    always_comb begin
        last_eff = (last == 2'd3) ? 2'd2 : last;
        start    = (last_eff == 2'd2) ? 2'd0 : last_eff + 2'd1;
        case (start)
            2'd0:    rot = req;
            2'd1:    rot = {req[0], req[2:1]};
            default: rot = {req[1:0], req[2]};
        endcase
        if (rot[0]) begin
            pick = 3'b001;
        end else if (rot[1]) begin
            pick = 3'b010;
        end else if (rot[2]) begin
            pick = 3'b100;
        end else begin
            pick = 3'b000;
        end
        case (start)
            2'd0:    gnt = pick;
            2'd1:    gnt = {pick[1], pick[0], pick[2]};
            default: gnt = {pick[0], pick[2], pick[1]};
        endcase
        if (!rst_n || flush) begin
            gnt = 3'b000;
        end
    end

    always_comb begin
        sel_reg  = wrreg0;
        sel_data = wrdata0;
        if (gnt[1]) begin
            sel_reg  = wrreg1;
            sel_data = wrdata1;
        end else if (gnt[2]) begin
            sel_reg  = wrreg2;
            sel_data = wrdata2;
        end
    end

    assign xfer = |gnt;

    // Writes to $zero still consume the requester but never raise regwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            wrreg    <= 5'd0;
            wrdata   <= 32'd0;
        end else begin
            regwrite <= xfer && (sel_reg != 5'd0);
            if (xfer) begin
                wrreg  <= sel_reg;
                wrdata <= sel_data;
            end
        end
    end

`ifdef REGWB_ARB_STATS_EN
    logic multi_req;
    assign multi_req = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    // Counts contention independent of flush; sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (multi_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: doc/regwb_arb.md
REGWB_ARB -- requirements
Module: regwb_arb

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall-statistics counter.
REQ-002 clk  input  1  single clock; all state on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 flush  input  1  synchronous kill; high blocks grants and clears the pending write.
REQ-005 req  input  3  per-requester write-back valid; bit i = requester i.
REQ-006 wrreg0, wrreg1, wrreg2  input  5 each  destination register of requester i.
REQ-007 wrdata0, wrdata1, wrdata2  input  32 each  write data of requester i.
REQ-008 gnt  output  3  one-hot or zero grant; combinational from req, flush and the round-robin pointer.
REQ-009 regwrite  output  1  registered write enable to the register memory.
REQ-010 wrreg  output  5  registered destination register to the register memory.
REQ-011 wrdata  output  32  registered write data to the register memory.
REQ-012 conflict_cnt  output  CNT_W  saturating count of cycles with two or more req bits high.

Function
REQ-013 Transfer: requester i transfers on a rising edge where req[i] and gnt[i] are both high.
REQ-014 Hold rule: requester holds req, wrreg and wrdata stable until granted.
REQ-015 At most one gnt bit high per cycle.
REQ-016 gnt[i] high only when req[i] is high and flush is low.
REQ-017 Round-robin: search starts at (last+1) mod 3, then wraps; first requesting index wins.
REQ-018 Pointer last is 2-bit state; loads the granted index on every transfer; unchanged otherwise.
REQ-019 Pointer value 3 is illegal; if it occurs, treat it as 2.
REQ-020 Latency: the transfer on edge N sets regwrite, wrreg and wrdata, visible from edge N until edge N+1.
REQ-021 Throughput: one transfer per cycle sustained; back-to-back grants have no bubble.
REQ-022 No transfer on edge N: regwrite low after edge N; wrreg and wrdata hold their previous values.
REQ-023 $zero: a transfer with wrreg==0 is granted and consumes the requester; regwrite stays low for it; pointer still advances.
REQ-024 Same destination: two requesters targeting the same register are written in grant order; the later grant wins in the register memory.
REQ-025 flush high at edge N: no transfer, pointer unchanged, regwrite low after edge N.
REQ-026 flush does not clear conflict_cnt.
REQ-027 A requester dropping req without a grant is a protocol error; the block tolerates it without lock-up.
REQ-028 Single requester: a lone requester is granted in the same cycle regardless of pointer.

Reset
REQ-029 rst_n low asynchronously forces regwrite=0, wrreg=0, wrdata=0, last=2 and conflict_cnt=0.
REQ-030 During reset gnt=0.
REQ-031 After reset, requester 0 has highest priority.
REQ-032 Reset mid-transfer discards any pending write; no regwrite pulse follows deassertion.
REQ-033 First transfer possible on the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro REGWB_ARB_STATS_EN.
REQ-035 Macro defined: conflict_cnt increments by 1 on each edge where two or more req bits are high (flush irrelevant) and saturates at all-ones.
REQ-036 Macro undefined: conflict_cnt is constant 0 and no counter flops exist; all other behaviour is identical.

Verification
REQ-037 Reset, then req=3'b111 held, all distinct registers, for 6 cycles -> grant order 0,1,2,0,1,2; regwrite high for 6 consecutive cycles, each one cycle after its grant.
REQ-038 req=3'b001, wrreg0=0, wrdata0=32'hDEADBEEF -> gnt=001 in the same cycle; regwrite stays 0 the following cycle; pointer=0.
REQ-039 req=3'b011, both targeting reg 5, data 32'h11 and 32'h22 -> two regwrite pulses to reg 5, data 11 then 22.
REQ-040 req=3'b100 with flush=1 for 2 cycles, then flush=0 -> gnt=0 and regwrite=0 while flushed; grant to requester 2 in the first unflushed cycle.
REQ-041 rst_n low in the cycle after a transfer to reg 7 -> regwrite=0 and wrreg=0 immediately; no pulse after release.
REQ-042 With REGWB_ARB_STATS_EN and CNT_W=4, req=3'b110 held 20 cycles -> conflict_cnt saturates at 15. Without the macro, conflict_cnt stays 0.
